// File: rtl/cm_sort_ser.sv
// rtl/cm_sort_ser.sv - two-slot vector FIFO that serialises sorted vectors one element per transfer.
// Define CM_SORT_SER_DESC_EN to emit each vector largest-first instead of smallest-first.
module cm_sort_ser #(
    parameter int DCNT   = 8,
    parameter int DWIDTH = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_vld,
    input  logic [DCNT-1:0][DWIDTH-1:0]    i_data,
    output logic                           o_vld,
    input  logic                           i_rdy,
    output logic [DWIDTH-1:0]              o_data,
    output logic [$clog2(DCNT)-1:0]        o_idx,
    output logic                           o_last,
    output logic                           o_ovf
);

    localparam int IW = $clog2(DCNT);
    localparam logic [IW-1:0] IDX_MAX = IW'(DCNT - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                      state_q;
    logic [DCNT-1:0][DWIDTH-1:0] slot_q [2];
    logic                        wr_q;
    logic                        rd_q;
    logic [1:0]                  count_q;
    logic [1:0]                  count_d;
    logic [IW-1:0]               idx_q;
    logic [IW-1:0]               idx_d;
    logic [IW-1:0]               rd_el;
    logic                        ovf_q;
    logic                        xfer;
    logic                        last_xfer;
    logic                        cap;
    logic                        drop;

    // A full FIFO can still accept a vector when its oldest slot frees up this very cycle.
    always_comb begin
        xfer      = (count_q != 2'd0) && i_rdy;
        last_xfer = xfer && (idx_q == IDX_MAX);
        cap       = i_vld && ((count_q != 2'd2) || last_xfer);
        drop      = i_vld && (count_q == 2'd2) && !last_xfer;

        count_d = count_q;
        if (cap && !last_xfer) begin
            count_d = count_q + 2'd1;
        end else if (!cap && last_xfer) begin
            count_d = count_q - 2'd1;
        end

        idx_d = idx_q;
        if (last_xfer) begin
            idx_d = '0;
        end else if (xfer) begin
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (cap) begin
                slot_q[wr_q] <= i_data;
                wr_q         <= ~wr_q;
            end
            if (last_xfer) begin
                rd_q <= ~rd_q;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_d;
            idx_q   <= idx_d;

            case (state_q)
                IDLE: begin
                    if (cap) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_xfer && !cap && (count_q == 2'd1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CM_SORT_SER_DESC_EN
    assign rd_el = IDX_MAX - idx_q;
`else
    assign rd_el = idx_q;
`endif

    assign o_vld  = (count_q != 2'd0);
    assign o_data = slot_q[rd_q][rd_el];
    assign o_idx  = idx_q;
    assign o_last = (idx_q == IDX_MAX);
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_cm_sort_ser.sv
// tb/tb_cm_sort_ser.sv - directed bench for cm_sort_ser with DCNT=4, DWIDTH=16.
module tb_cm_sort_ser;

    localparam int DCNT   = 4;
    localparam int DWIDTH = 16;

    typedef logic [DCNT-1:0][DWIDTH-1:0] vec_t;

    logic              clk;
    logic              rst;
    logic              vld;
    vec_t              data;
    logic              rdy;
    logic              o_vld;
    logic [DWIDTH-1:0] o_data;
    logic [1:0]        o_idx;
    logic              o_last;
    logic              o_ovf;

    int checks;
    int errors;

    cm_sort_ser #(.DCNT(DCNT), .DWIDTH(DWIDTH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_vld  (vld),
        .i_data (data),
        .o_vld  (o_vld),
        .i_rdy  (rdy),
        .o_data (o_data),
        .o_idx  (o_idx),
        .o_last (o_last),
        .o_ovf  (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = a[15:0];
        v[1] = b[15:0];
        v[2] = c[15:0];
        v[3] = d[15:0];
        return v;
    endfunction

    // Element expected at output position n of a vector.
    function automatic int el(input vec_t v, input int n);
`ifdef CM_SORT_SER_DESC_EN
        return int'(v[DCNT-1-n]);
`else
        return int'(v[n]);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Checks a full vector streaming with i_rdy held high, starting at the current cycle.
    task automatic stream_check(input string tag, input vec_t v);
        for (int n = 0; n < DCNT; n++) begin
            check({tag, "_vld"}, 32'(o_vld), 32'd1);
            check({tag, "_data"}, 32'(o_data), 32'(el(v, n)));
            check({tag, "_idx"}, 32'(o_idx), 32'(n));
            check({tag, "_last"}, 32'(o_last), 32'(n == DCNT - 1));
            tick();
        end
    endtask

    initial begin
        vec_t va;
        vec_t vb;
        vec_t vc;
        int   got;
        int   cyc;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        vld    = 1'b0;
        rdy    = 1'b0;
        data   = '0;

        // Reset state
        do_reset();
        check("rst_vld", 32'(o_vld), 32'd0);
        check("rst_idx", 32'(o_idx), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);

        // Single vector, i_rdy held high, one-cycle latency
        va   = mk(3, 7, 9, 12);
        rdy  = 1'b1;
        vld  = 1'b1;
        data = va;
        tick();
        vld = 1'b0;
        stream_check("single", va);
        check("single_idle", 32'(o_vld), 32'd0);

        // i_rdy toggling: element held while stalled
        vld  = 1'b1;
        data = va;
        tick();
        vld = 1'b0;
        got = 0;
        cyc = 0;
        while (got < DCNT && cyc < 40) begin
            rdy = (cyc % 2 == 0);
            check("tog_vld", 32'(o_vld), 32'd1);
            check("tog_data", 32'(o_data), 32'(el(va, got)));
            check("tog_idx", 32'(o_idx), 32'(got));
            if (rdy && o_vld) got++;
            tick();
            cyc++;
        end
        check("tog_count", 32'(got), 32'(DCNT));
        check("tog_idle", 32'(o_vld), 32'd0);

        // Two vectors back to back: contiguous stream
        va   = mk(1, 2, 3, 4);
        vb   = mk(5, 6, 7, 8);
        rdy  = 1'b1;
        vld  = 1'b1;
        data = va;
        tick();
        data = vb;
        for (int k = 0; k < 2 * DCNT; k++) begin
            check("b2b_vld", 32'(o_vld), 32'd1);
            check("b2b_data", 32'(o_data), 32'(k < DCNT ? el(va, k) : el(vb, k - DCNT)));
            tick();
            vld = 1'b0;
        end
        check("b2b_idle", 32'(o_vld), 32'd0);
        check("b2b_ovf", 32'(o_ovf), 32'd0);

        // Overflow: third vector dropped while stalled
        vc   = mk(100, 101, 102, 103);
        rdy  = 1'b0;
        vld  = 1'b1;
        data = va;
        tick();
        data = vb;
        tick();
        check("ovf_pre", 32'(o_ovf), 32'd0);
        data = vc;
        tick();
        vld = 1'b0;
        check("ovf_set", 32'(o_ovf), 32'd1);
        check("ovf_hold_data", 32'(o_data), 32'(el(va, 0)));
        rdy = 1'b1;
        stream_check("ovf_v1", va);
        stream_check("ovf_v2", vb);
        check("ovf_idle", 32'(o_vld), 32'd0);
        check("ovf_sticky", 32'(o_ovf), 32'd1);

        // Reset mid-vector
        do_reset();
        check("ovf_clr", 32'(o_ovf), 32'd0);
        rdy  = 1'b1;
        vld  = 1'b1;
        data = vc;
        tick();
        vld = 1'b0;
        tick();
        tick();
        check("mid_idx2", 32'(o_idx), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_vld", 32'(o_vld), 32'd0);
        check("mid_idx", 32'(o_idx), 32'd0);
        check("mid_last", 32'(o_last), 32'd0);
        va   = mk(10, 20, 30, 40);
        vld  = 1'b1;
        data = va;
        tick();
        vld = 1'b0;
        stream_check("post_rst", va);
        check("post_rst_idle", 32'(o_vld), 32'd0);

        // Full FIFO accepts a vector on the cycle its oldest last element transfers
        va   = mk(1, 2, 3, 4);
        vb   = mk(5, 6, 7, 8);
        vc   = mk(9, 10, 11, 12);
        rdy  = 1'b0;
        vld  = 1'b1;
        data = va;
        tick();
        data = vb;
        tick();
        vld = 1'b0;
        rdy = 1'b1;
        for (int k = 0; k < 3 * DCNT; k++) begin
            if (k == DCNT - 1) begin
                vld  = 1'b1;
                data = vc;
            end
            check("full_vld", 32'(o_vld), 32'd1);
            check("full_data", 32'(o_data),
                  32'(k < DCNT ? el(va, k) : (k < 2 * DCNT ? el(vb, k - DCNT) : el(vc, k - 2 * DCNT))));
            tick();
            vld = 1'b0;
        end
        check("full_idle", 32'(o_vld), 32'd0);
        check("full_ovf", 32'(o_ovf), 32'd0);

        // Vector coinciding with reset is discarded
        rst  = 1'b1;
        vld  = 1'b1;
        data = va;
        tick();
        rst = 1'b0;
        vld = 1'b0;
        check("rst_vec_drop", 32'(o_vld), 32'd0);
        tick();
        check("rst_vec_drop2", 32'(o_vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
